// File: rtl/key_conditioner_pkg.sv
// Shared types, default timing constants and width helper for the key conditioner.
package key_conditioner_pkg;

  localparam int unsigned KEY_DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int unsigned RESET_HOLD_CYCLES_DEF   = 16;

  typedef enum logic [1:0] {
    RST_ACTIVE = 2'd0,
    RST_HOLD   = 2'd1,
    RUN        = 2'd2
  } rst_state_e;

  // Bits needed to count 0 .. value-1; never less than one bit.
  function automatic int unsigned log2(input int unsigned value);
    log2 = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < value) log2 = i + 1;
    end
  endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key pins in, conditioned reset / interrupt / key status out.
interface key_conditioner_if #(
  parameter int unsigned KEY_NUM = 4
);
  logic [KEY_NUM-1:0] key_i;
  logic               soc_reset_o;
  logic [KEY_NUM-2:0] ext_int_o;
  logic [KEY_NUM-1:0] key_press_o;
  logic [KEY_NUM-1:0] key_level_o;

  modport master (
    output key_i,
    input  soc_reset_o, ext_int_o, key_press_o, key_level_o
  );

  modport slave (
    input  key_i,
    output soc_reset_o, ext_int_o, key_press_o, key_level_o
  );
endinterface

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchroniser, counter debouncer, press-edge pulse.
module key_debounce_cell
  import key_conditioner_pkg::*;
#(
  parameter int unsigned KEY_ACTIVE_LOW  = 1,
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic key_i,
  output logic level_o,
  output logic level_next_o,
  output logic press_o
);

  localparam int unsigned     CNT_W      = log2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic            IDLE_LEVEL = (KEY_ACTIVE_LOW != 0);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sampled;

  assign sampled = sync2_q ^ IDLE_LEVEL;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sampled != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sampled;
        press_d  = sampled;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= IDLE_LEVEL;
      sync2_q  <= IDLE_LEVEL;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= key_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign level_o      = stable_q;
  assign level_next_o = stable_d;
  assign press_o      = press_q;

endmodule

// File: rtl/key_conditioner.sv
// DE2-115 push-button conditioner: per-key debounce plus stretched SoC reset from key 0.
module key_conditioner
  import key_conditioner_pkg::*;
#(
  parameter int unsigned KEY_NUM           = 4,
  parameter int unsigned KEY_ACTIVE_LOW    = 1,
  parameter int unsigned DEBOUNCE_CYCLES   = KEY_DEBOUNCE_CYCLES_DEF,
  parameter int unsigned RESET_HOLD_CYCLES = RESET_HOLD_CYCLES_DEF
) (
  input logic               clk,
  input logic               reset,
  key_conditioner_if.slave  kc
);

  localparam int unsigned      HOLD_W    = log2(RESET_HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

  logic [KEY_NUM-1:0] level, level_next, press;
  rst_state_e         state_q, state_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic               soc_reset_q, soc_reset_d;

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_key
    key_debounce_cell #(
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_cell (
      .clk          (clk),
      .reset        (reset),
      .key_i        (kc.key_i[g]),
      .level_o      (level[g]),
      .level_next_o (level_next[g]),
      .press_o      (press[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RST_ACTIVE;
      hold_cnt_q  <= '0;
      soc_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      soc_reset_q <= soc_reset_d;
    end
  end

  // FSM follows key 0's next debounced level so soc_reset_o moves on the
  // same edge as key_level_o[0] and release-to-deassert is exactly the hold time.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      RST_ACTIVE: begin
        if (!level_next[0]) begin
          state_d    = RST_HOLD;
          hold_cnt_d = '0;
        end
      end
      RST_HOLD: begin
        if (level_next[0])                state_d = RST_ACTIVE;
        else if (hold_cnt_q == HOLD_LAST) state_d = RUN;
        else                              hold_cnt_d = hold_cnt_q + 1'b1;
      end
      RUN: begin
        if (level_next[0]) state_d = RST_ACTIVE;
      end
      default: state_d = RST_ACTIVE;
    endcase
  end

  always_comb begin
    soc_reset_d = (state_d != RUN);
  end

  assign kc.soc_reset_o = soc_reset_q;
  assign kc.key_level_o = level;
  assign kc.key_press_o = press;
  assign kc.ext_int_o   = level[KEY_NUM-1:1];

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: DEBOUNCE_CYCLES=8, RESET_HOLD_CYCLES=4, active-low keys.
module tb_key_conditioner;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  key_conditioner_if #(.KEY_NUM(4)) kif ();

  key_conditioner #(
    .KEY_NUM           (4),
    .KEY_ACTIVE_LOW    (1),
    .DEBOUNCE_CYCLES   (8),
    .RESET_HOLD_CYCLES (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kc    (kif)
  );

  // Packed view: {soc_reset, ext_int[2:0], press[3:0], level[3:0]}
  function automatic logic [11:0] frame(input logic soc, input logic [3:0] press,
                                        input logic [3:0] level);
    return {soc, level[3:1], press, level};
  endfunction

  function automatic logic [11:0] observe();
    return {kif.soc_reset_o, kif.ext_int_o, kif.key_press_o, kif.key_level_o};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] e, o;
    reset = 1'b1;
    kif.key_i = 4'hF;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(frame(1'b1, 4'h0, 4'h0));
      step();
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_asserted cyc=%0d got=%h want=%h", i, o, e);
      end
    end
    reset = 1'b0;
    for (int s = 1; s <= 10; s++) begin
      exp_q.push_back(frame(s < 5, 4'h0, 4'h0));
      step();
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_release s=%0d got=%h want=%h", s, o, e);
      end
    end
  endtask

  task automatic test_press();
    logic [11:0] e, o;
    logic [3:0]  lvl, pr;
    int          pulses = 0;
    for (int t = 0; t < 34; t++) begin
      int s = t + 1;
      kif.key_i = (t < 20) ? 4'b1101 : 4'hF;
      lvl = (s >= 10 && s < 30) ? 4'b0010 : 4'b0000;
      pr  = (s == 10) ? 4'b0010 : 4'b0000;
      exp_q.push_back(frame(1'b0, pr, lvl));
      step();
      e = exp_q.pop_front(); o = observe(); checks++;
      if (kif.key_press_o[1] === 1'b1) pulses++;
      if (o !== e) begin
        failures++;
        $display("FAIL press_key1 s=%0d got=%h want=%h", s, o, e);
      end
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL press_key1_pulse_count got=%0d want=1", pulses);
    end
  endtask

  task automatic test_bounce();
    logic [11:0] e, o;
    logic        k;
    for (int t = 0; t < 55; t++) begin
      k = (t < 40) ? ((t / 5) % 2 == 1) : 1'b1;
      kif.key_i = {1'b1, k, 2'b11};
      exp_q.push_back(frame(1'b0, 4'h0, 4'h0));
      step();
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL bounce_key2 s=%0d got=%h want=%h", t + 1, o, e);
      end
    end
  endtask

  // Key 0 held 12 cycles; optional single-cycle glitch while the reset is held.
  task automatic test_reset_key(input bit glitch, input int len);
    logic [11:0] e, o;
    logic        k0;
    for (int t = 0; t < len; t++) begin
      int s = t + 1;
      k0 = (t < 12) ? 1'b0 : 1'b1;
      if (glitch && t == 23) k0 = 1'b0;
      kif.key_i = {3'b111, k0};
      exp_q.push_back(frame(s >= 10 && s < 26, (s == 10) ? 4'b0001 : 4'b0000,
                            (s >= 10 && s < 22) ? 4'b0001 : 4'b0000));
      step();
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL %s s=%0d got=%h want=%h", glitch ? "hold_glitch" : "reset_key",
                 s, o, e);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [11:0] e, o;
    for (int t = 0; t < 24; t++) begin
      int s = t + 1;
      kif.key_i = (t < 12) ? 4'b0001 : 4'hF;
      exp_q.push_back(frame(1'b0, (s == 10) ? 4'b1110 : 4'b0000,
                            (s >= 10 && s < 22) ? 4'b1110 : 4'b0000));
      step();
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL simultaneous s=%0d got=%h want=%h", s, o, e);
      end
    end
    for (int t = 24; t < 30; t++) begin
      kif.key_i = 4'b0001;
      exp_q.push_back(frame(1'b0, 4'h0, 4'h0));
      step();
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL midcount s=%0d got=%h want=%h", t + 1, o, e);
      end
    end
    #2;
    reset = 1'b1;
    kif.key_i = 4'hF;
    exp_q.push_back(frame(1'b1, 4'h0, 4'h0));
    #1;
    e = exp_q.pop_front(); o = observe(); checks++;
    if (o !== e) begin
      failures++;
      $display("FAIL async_reset_immediate got=%h want=%h", o, e);
    end
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(frame(1'b1, 4'h0, 4'h0));
      step();
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL async_reset_held cyc=%0d got=%h want=%h", i, o, e);
      end
    end
    reset = 1'b0;
    for (int s = 1; s <= 12; s++) begin
      exp_q.push_back(frame(s < 5, 4'h0, 4'h0));
      step();
      e = exp_q.pop_front(); o = observe(); checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL post_reset_no_late_pulse s=%0d got=%h want=%h", s, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bounce();
    test_reset_key(1'b0, 32);
    test_reset_key(1'b1, 40);
    test_simultaneous();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
